// File: rtl/axil_reg_pkg.sv
// axil_reg_pkg: shared definitions for the AXI4-Lite register slave.
//   - register byte offsets (IIC-style map: GIE 0x1C, ISR 0x20, IER 0x28)
//   - AXI response codes
//   - address-decode enum plus decode and byte-strobe helpers
// Optional feature macro: AXIL_REG_IRQ_EN (interrupt registers decoded only
// when defined; otherwise their offsets decode as unmapped).
package axil_reg_pkg;

    localparam logic [31:0] OFF_ID      = 32'h00;
    localparam logic [31:0] OFF_CTRL    = 32'h04;
    localparam logic [31:0] OFF_SCRATCH = 32'h08;
    localparam logic [31:0] OFF_GIE     = 32'h1C;
    localparam logic [31:0] OFF_ISR     = 32'h20;
    localparam logic [31:0] OFF_IER     = 32'h28;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        DEC_ID,
        DEC_CTRL,
        DEC_SCRATCH,
        DEC_GIE,
        DEC_ISR,
        DEC_IER,
        DEC_NONE
    } dec_e;

    // Byte-lane bits [1:0] of the address are ignored.
    function automatic dec_e decode(input logic [31:0] addr);
        dec_e sel;
        case (addr & 32'hFFFF_FFFC)
            OFF_ID:      sel = DEC_ID;
            OFF_CTRL:    sel = DEC_CTRL;
            OFF_SCRATCH: sel = DEC_SCRATCH;
`ifdef AXIL_REG_IRQ_EN
            OFF_GIE:     sel = DEC_GIE;
            OFF_ISR:     sel = DEC_ISR;
            OFF_IER:     sel = DEC_IER;
`endif
            default:     sel = DEC_NONE;
        endcase
        return sel;
    endfunction

    // Expand a 4-bit byte strobe to a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/axil_reg_slave_irq.sv
// axil_reg_slave_irq: level-sensitive interrupt controller (GIE/ISR/IER).
// Instantiated by axil_reg_slave only when AXIL_REG_IRQ_EN is defined.
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_irq_src          level interrupt sources, sampled every edge
//   i_wr_en, i_wr_sel  committed write strobe and its decoded target
//   i_wdata, i_wmask   low N_IRQ bits of write data and bit mask
//   i_gie_data/mask    write data bit 31 and its byte-3 enable
//   o_isr, o_ier, o_gie register contents for readback
//   o_irq              registered interrupt output
module axil_reg_slave_irq
    import axil_reg_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_IRQ-1:0] i_irq_src,
    input  logic             i_wr_en,
    input  dec_e             i_wr_sel,
    input  logic [N_IRQ-1:0] i_wdata,
    input  logic [N_IRQ-1:0] i_wmask,
    input  logic             i_gie_data,
    input  logic             i_gie_mask,
    output logic [N_IRQ-1:0] o_isr,
    output logic [N_IRQ-1:0] o_ier,
    output logic             o_gie,
    output logic             o_irq
);

    logic [N_IRQ-1:0] r_isr;
    logic [N_IRQ-1:0] r_ier;
    logic             r_gie;
    logic             r_irq;
    logic [N_IRQ-1:0] w_clr;
    logic [N_IRQ-1:0] w_ier_next;
    logic             w_isr_wr;
    logic             w_ier_wr;

    assign w_isr_wr = i_wr_en && (i_wr_sel == DEC_ISR);
    assign w_ier_wr = i_wr_en && (i_wr_sel == DEC_IER);

    generate
        for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_bit
            assign w_clr[gi]      = w_isr_wr && i_wdata[gi] && i_wmask[gi];
            assign w_ier_next[gi] = (w_ier_wr && i_wmask[gi]) ? i_wdata[gi] : r_ier[gi];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_isr <= '0;
            r_ier <= '0;
            r_gie <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            // A source asserted on the clearing edge keeps its bit set.
            r_isr <= (r_isr & ~w_clr) | i_irq_src;
            r_ier <= w_ier_next;
            if (i_wr_en && (i_wr_sel == DEC_GIE) && i_gie_mask) begin
                r_gie <= i_gie_data;
            end
            r_irq <= r_gie & (|(r_isr & r_ier));
        end
    end

    assign o_isr = r_isr;
    assign o_ier = r_ier;
    assign o_gie = r_gie;
    assign o_irq = r_irq;

endmodule

// File: rtl/axil_reg_slave.sv
// axil_reg_slave: AXI4-Lite slave with ID/CTRL/SCRATCH registers and an
// optional interrupt controller (macro AXIL_REG_IRQ_EN).
// Ports:
//   ACLK, ARESETN              clock, synchronous active-low reset
//   AW*/W*/B*                  write address, data and response channels
//   AR*/R*                     read address and data channels
//   irq_src                    level interrupt sources (ignored without IRQ)
//   ctrl_o                     CTRL register contents
//   irq                        registered interrupt output (0 without IRQ)
module axil_reg_slave
    import axil_reg_pkg::*;
#(
    parameter int          ADDR_W   = 9,
    parameter logic [31:0] ID_VAL   = 32'h0A11_0001,
    parameter logic [31:0] CTRL_RST = 32'h0,
    parameter int          N_IRQ    = 8
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [31:0]       WDATA,
    input  logic [3:0]        WSTRB,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [31:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY,
    input  logic [N_IRQ-1:0]  irq_src,
    output logic [31:0]       ctrl_o,
    output logic              irq
);

    // r_rdy keeps all READY outputs low until the first edge after reset.
    logic              r_rdy;
    logic              r_aw_full;
    logic [ADDR_W-1:0] r_aw_addr;
    logic              r_w_full;
    logic [31:0]       r_w_data;
    logic [3:0]        r_w_strb;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic              r_rvalid;
    logic [1:0]        r_rresp;
    logic [31:0]       r_rdata;
    logic [31:0]       r_ctrl;
    logic [31:0]       r_scratch;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_ar_hs;
    logic              w_commit;
    dec_e              w_wr_dec;
    dec_e              w_rd_dec;
    logic [31:0]       w_mask;
    logic [31:0]       w_rd_data;
    logic [N_IRQ-1:0]  w_isr;
    logic [N_IRQ-1:0]  w_ier;
    logic              w_gie;
    logic              w_irq;

    assign AWREADY  = r_rdy && !r_aw_full && !r_bvalid;
    assign WREADY   = r_rdy && !r_w_full && !r_bvalid;
    assign ARREADY  = r_rdy && !r_rvalid;

    assign w_aw_hs  = AWVALID && AWREADY;
    assign w_w_hs   = WVALID && WREADY;
    assign w_ar_hs  = ARVALID && ARREADY;
    assign w_commit = r_aw_full && r_w_full;
    assign w_wr_dec = decode(32'(r_aw_addr));
    assign w_rd_dec = decode(32'(ARADDR));
    assign w_mask   = strb_mask(r_w_strb);

`ifdef AXIL_REG_IRQ_EN
    axil_reg_slave_irq #(
        .N_IRQ (N_IRQ)
    ) u_irq (
        .i_clk      (ACLK),
        .i_rst_n    (ARESETN),
        .i_irq_src  (irq_src),
        .i_wr_en    (w_commit),
        .i_wr_sel   (w_wr_dec),
        .i_wdata    (r_w_data[N_IRQ-1:0]),
        .i_wmask    (w_mask[N_IRQ-1:0]),
        .i_gie_data (r_w_data[31]),
        .i_gie_mask (w_mask[31]),
        .o_isr      (w_isr),
        .o_ier      (w_ier),
        .o_gie      (w_gie),
        .o_irq      (w_irq)
    );
`else
    logic w_unused_irq_src;
    assign w_unused_irq_src = ^irq_src;
    assign w_isr = '0;
    assign w_ier = '0;
    assign w_gie = 1'b0;
    assign w_irq = 1'b0;
`endif

    always_comb begin
        w_rd_data = '0;
        case (w_rd_dec)
            DEC_ID:      w_rd_data = ID_VAL;
            DEC_CTRL:    w_rd_data = r_ctrl;
            DEC_SCRATCH: w_rd_data = r_scratch;
            DEC_GIE:     w_rd_data[31] = w_gie;
            DEC_ISR:     w_rd_data[N_IRQ-1:0] = w_isr;
            DEC_IER:     w_rd_data[N_IRQ-1:0] = w_ier;
            default:     w_rd_data = '0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_rdy     <= 1'b0;
            r_aw_full <= 1'b0;
            r_aw_addr <= '0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
            r_ctrl    <= CTRL_RST;
            r_scratch <= '0;
        end else begin
            r_rdy <= 1'b1;
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_addr <= AWADDR;
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_w_data <= WDATA;
                r_w_strb <= WSTRB;
            end
            // Holds can only fill while BVALID is low, so commit and a pending
            // B response never coexist.
            if (w_commit) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= (w_wr_dec == DEC_NONE) ? RESP_SLVERR : RESP_OKAY;
                case (w_wr_dec)
                    DEC_CTRL:    r_ctrl    <= (r_ctrl & ~w_mask) | (r_w_data & w_mask);
                    DEC_SCRATCH: r_scratch <= (r_scratch & ~w_mask) | (r_w_data & w_mask);
                    default:     ;
                endcase
            end else if (r_bvalid && BREADY) begin
                r_bvalid <= 1'b0;
            end
            // Read data samples pre-edge register values, so a read on the
            // commit edge of a write returns the old contents.
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= (w_rd_dec == DEC_NONE) ? RESP_SLVERR : RESP_OKAY;
            end else if (r_rvalid && RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign BVALID = r_bvalid;
    assign BRESP  = r_bresp;
    assign RVALID = r_rvalid;
    assign RRESP  = r_rresp;
    assign RDATA  = r_rdata;
    assign ctrl_o = r_ctrl;
    assign irq    = w_irq;

endmodule

// File: tb/tb_axil_reg_slave.sv
`timescale 1ns/1ps
module tb_axil_reg_slave;

    localparam int          ADDR_W   = 9;
    localparam logic [31:0] ID_VAL   = 32'h0A11_0001;
    localparam logic [31:0] CTRL_RST = 32'h0;
    localparam int          N_IRQ    = 8;
    localparam logic [31:0] IRQ_MASK = (N_IRQ == 32) ? 32'hFFFF_FFFF : ((32'h1 << N_IRQ) - 32'h1);
`ifdef AXIL_REG_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic              ACLK = 1'b0;
    logic              ARESETN;
    logic [ADDR_W-1:0] AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [31:0]       WDATA;
    logic [3:0]        WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;
    logic [N_IRQ-1:0]  irq_src;
    logic [31:0]       ctrl_o;
    logic              irq;

    always #5 ACLK = ~ACLK;

    axil_reg_slave #(
        .ADDR_W   (ADDR_W),
        .ID_VAL   (ID_VAL),
        .CTRL_RST (CTRL_RST),
        .N_IRQ    (N_IRQ)
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .AWADDR  (AWADDR),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARADDR  (ARADDR),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .irq_src (irq_src),
        .ctrl_o  (ctrl_o),
        .irq     (irq)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference register file, expressed directly as the programmer-visible map.
    logic [31:0] m_ctrl;
    logic [31:0] m_scratch;
    logic [31:0] m_isr;
    logic [31:0] m_ier;
    logic        m_gie;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_off(input logic [31:0] a);
        return a & 32'h0000_01FC;
    endfunction

    function automatic bit m_mapped(input logic [31:0] a);
        case (word_off(a))
            32'h00, 32'h04, 32'h08:  return 1'b1;
            32'h1C, 32'h20, 32'h28:  return IRQ_EN;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] bytemask(input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = s[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_mapped(a)) return 32'h0;
        case (word_off(a))
            32'h00:  return ID_VAL;
            32'h04:  return m_ctrl;
            32'h08:  return m_scratch;
            32'h1C:  return {m_gie, 31'h0};
            32'h20:  return m_isr;
            32'h28:  return m_ier;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_irq();
        return {31'h0, m_gie && ((m_isr & m_ier) != 32'h0)};
    endfunction

    task automatic m_reset();
        m_ctrl = CTRL_RST; m_scratch = 0; m_isr = 0; m_ier = 0; m_gie = 1'b0;
    endtask

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] bm;
        bm = bytemask(s);
        if (m_mapped(a)) begin
            case (word_off(a))
                32'h04: m_ctrl    = (m_ctrl & ~bm) | (d & bm);
                32'h08: m_scratch = (m_scratch & ~bm) | (d & bm);
                32'h1C: if (s[3]) m_gie = d[31];
                32'h20: m_isr     = m_isr & ~(d & bm);
                32'h28: m_ier     = ((m_ier & ~bm) | (d & bm)) & IRQ_MASK;
                default: ;
            endcase
        end
        // Sources that are high keep setting their ISR bit, clear or not.
        if (IRQ_EN) m_isr = m_isr | (32'(irq_src) & IRQ_MASK);
    endtask

    // Called at #1 after an edge with the interface idle.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int w_dly, input int b_dly);
        logic [1:0] exp_resp;
        exp_resp = m_mapped(a) ? 2'b00 : 2'b10;
        check("awready_idle", 32'(AWREADY), 32'd1);
        check("wready_idle", 32'(WREADY), 32'd1);
        AWADDR = a[ADDR_W-1:0]; AWVALID = 1'b1;
        WDATA = d; WSTRB = s;
        if (w_dly == 0) WVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        if (w_dly == 0) begin
            WVALID = 1'b0;
        end else begin
            for (int i = 1; i < w_dly; i++) begin
                check("awready_held", 32'(AWREADY), 32'd0);
                check("bvalid_early", 32'(BVALID), 32'd0);
                @(posedge ACLK); #1;
            end
            WVALID = 1'b1;
            @(posedge ACLK); #1;
            WVALID = 1'b0;
        end
        check("bvalid_pre", 32'(BVALID), 32'd0);
        check("wready_full", 32'(WREADY), 32'd0);
        @(posedge ACLK); #1;
        m_write(a, d, s);
        check("bvalid", 32'(BVALID), 32'd1);
        check("bresp", 32'(BRESP), 32'(exp_resp));
        check("ctrl_o", ctrl_o, m_ctrl);
        for (int i = 0; i < b_dly; i++) begin
            @(posedge ACLK); #1;
            if (IRQ_EN) m_isr = m_isr | (32'(irq_src) & IRQ_MASK);
            check("bvalid_hold", 32'(BVALID), 32'd1);
            check("bresp_hold", 32'(BRESP), 32'(exp_resp));
            check("awready_busy", 32'(AWREADY), 32'd0);
            check("wready_busy", 32'(WREADY), 32'd0);
        end
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        if (IRQ_EN) m_isr = m_isr | (32'(irq_src) & IRQ_MASK);
        check("bvalid_clr", 32'(BVALID), 32'd0);
        check("irq", 32'(irq), m_irq());
        $display("WR addr=%h data=%h strb=%b wdly=%0d bdly=%0d bresp=%0d", a, d, s, w_dly, b_dly, BRESP);
    endtask

    task automatic do_read(input logic [31:0] a, input int r_dly);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        exp_d = m_read(a);
        exp_r = m_mapped(a) ? 2'b00 : 2'b10;
        check("arready_idle", 32'(ARREADY), 32'd1);
        ARADDR = a[ADDR_W-1:0]; ARVALID = 1'b1;
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        check("rvalid", 32'(RVALID), 32'd1);
        check("rdata", RDATA, exp_d);
        check("rresp", 32'(RRESP), 32'(exp_r));
        check("arready_busy", 32'(ARREADY), 32'd0);
        for (int i = 0; i < r_dly; i++) begin
            @(posedge ACLK); #1;
            check("rvalid_hold", 32'(RVALID), 32'd1);
            check("rdata_hold", RDATA, exp_d);
        end
        RREADY = 1'b1;
        @(posedge ACLK); #1;
        RREADY = 1'b0;
        check("rvalid_clr", 32'(RVALID), 32'd0);
        $display("RD addr=%h rdata=%h rresp=%0d", a, exp_d, exp_r);
    endtask

    localparam int N_OFFS = 8;
    logic [31:0] offs [N_OFFS] = '{32'h00, 32'h04, 32'h08, 32'h1C, 32'h20, 32'h28, 32'h30, 32'h3C};

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] old_v;
        logic [31:0] a;
        ARESETN = 1'b0; AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        BREADY = 1'b0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0; irq_src = '0;
        m_reset();
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_awready", 32'(AWREADY), 32'd0);
        check("rst_wready", 32'(WREADY), 32'd0);
        check("rst_arready", 32'(ARREADY), 32'd0);
        check("rst_bvalid", 32'(BVALID), 32'd0);
        check("rst_rvalid", 32'(RVALID), 32'd0);
        check("rst_bresp", 32'(BRESP), 32'd0);
        check("rst_rresp", 32'(RRESP), 32'd0);
        check("rst_rdata", RDATA, 32'd0);
        check("rst_ctrl", ctrl_o, CTRL_RST);
        check("rst_irq", 32'(irq), 32'd0);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        check("post_rst_awready", 32'(AWREADY), 32'd1);
        check("post_rst_arready", 32'(ARREADY), 32'd1);

        // Directed cases
        do_read(32'h00, 0);
        do_write(32'h04, 32'hDEAD_BEEF, 4'b0011, 0, 0);
        check("ctrl_beef", ctrl_o, 32'h0000_BEEF);
        do_write(32'h08, 32'h1234_5678, 4'b1111, 3, 4);
        do_read(32'h08, 2);
        do_read(32'h30, 0);
        do_write(32'h30, 32'hFFFF_FFFF, 4'b1111, 0, 0);
        do_read(32'h04, 0);
        do_read(32'h0B, 0);

        // Read of SCRATCH on the same edge as a write commit to SCRATCH
        old_v = m_scratch;
        AWADDR = 9'h008; AWVALID = 1'b1; WDATA = 32'hCAFE_F00D; WSTRB = 4'hF; WVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        ARADDR = 9'h008; ARVALID = 1'b1;
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        m_write(32'h08, 32'hCAFE_F00D, 4'hF);
        check("same_edge_rvalid", 32'(RVALID), 32'd1);
        check("same_edge_rdata", RDATA, old_v);
        check("same_edge_bvalid", 32'(BVALID), 32'd1);
        RREADY = 1'b1; BREADY = 1'b1;
        @(posedge ACLK); #1;
        RREADY = 1'b0; BREADY = 1'b0;
        $display("RW same-edge scratch old=%h new=%h", old_v, m_scratch);
        do_read(32'h08, 0);

`ifdef AXIL_REG_IRQ_EN
        do_write(32'h28, 32'h0000_00FF, 4'hF, 0, 0);
        do_write(32'h1C, 32'h8000_0000, 4'hF, 0, 0);
        irq_src = 8'h04;
        @(posedge ACLK); #1;
        irq_src = '0;
        m_isr = m_isr | 32'h4;
        check("irq_lag", 32'(irq), 32'd0);
        @(posedge ACLK); #1;
        check("irq_set", 32'(irq), 32'd1);
        do_read(32'h20, 0);
        check("isr_val", RDATA, 32'h4);
        do_write(32'h20, 32'h4, 4'hF, 0, 0);
        check("irq_cleared", 32'(irq), 32'd0);
        do_read(32'h20, 0);
        irq_src = 8'h04;
        @(posedge ACLK); #1;
        m_isr = m_isr | 32'h4;
        do_write(32'h20, 32'h4, 4'hF, 0, 0);
        do_read(32'h20, 0);
        check("isr_set_wins", RDATA, 32'h4);
        irq_src = '0;
        do_write(32'h20, 32'hFF, 4'h1, 0, 0);
        do_read(32'h1C, 0);
`else
        irq_src = '1;
        do_read(32'h1C, 0);
        do_read(32'h20, 0);
        do_write(32'h28, 32'h0000_00FF, 4'hF, 0, 0);
        check("irq_disabled", 32'(irq), 32'd0);
`endif

        // Randomized traffic against the reference map
        for (int t = 0; t < 80; t++) begin
`ifndef AXIL_REG_IRQ_EN
            irq_src = N_IRQ'($urandom);
`endif
            if ($urandom_range(0, 4) == 0)
                a = 32'($urandom_range(0, 127)) << 2;
            else
                a = offs[$urandom_range(0, N_OFFS-1)];
            a = a | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 2));
        end
        irq_src = '0;

        // Reset while a read response is pending
        do_write(32'h04, 32'hA5A5_5A5A, 4'hF, 0, 0);
        ARADDR = 9'h004; ARVALID = 1'b1;
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        check("pend_rvalid", 32'(RVALID), 32'd1);
        ARESETN = 1'b0;
        @(posedge ACLK); #1;
        check("abort_rvalid", 32'(RVALID), 32'd0);
        check("abort_ctrl", ctrl_o, CTRL_RST);
        check("abort_arready", 32'(ARREADY), 32'd0);
        ARESETN = 1'b1;
        m_reset();
        @(posedge ACLK); #1;
        $display("RST during pending read");
        do_read(32'h04, 0);
        do_read(32'h08, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
